// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART port arbiter.
// TX state encoding and UART register-port constants.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_WRITE = 2'd1,
        TX_GAP   = 2'd2
    } tx_state_e;

    localparam logic [31:0] UART_NO_DATA = 32'hFFFF_FFFF;
    localparam int          UART_BYTE_W  = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// The search starts at ptr and wraps modulo N; the pointer register lives in the caller.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!gnt_any && req[idx]) begin
                gnt_any  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/uart_port_arbiter.sv
// Shares one simpleuart data register between NREQ transmit requesters and one receiver.
// TX: round-robin grant, write handshake, one-cycle gap. RX: poll and strobe each received byte.
module uart_port_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                        hw_clk,
    input  logic                        resetn,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*UART_BYTE_W-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        rx_valid,
    output logic [UART_BYTE_W-1:0]      rx_data,
    output logic                        uart_we,
    output logic [31:0]                 uart_di,
    input  logic                        uart_wait,
    output logic                        uart_re,
    input  logic [31:0]                 uart_do
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    tx_state_e              state, state_nxt;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          gnt_idx;
    logic [NREQ-1:0]        gnt;
    logic                   gnt_any;
    logic [UART_BYTE_W-1:0] tx_byte;
    logic                   byte_pending;
    logic                   unused_do;

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // The accept pulse is Mealy; gating with resetn keeps it silent while reset is held.
    always_comb begin
        state_nxt = state;
        req_ready = '0;
        uart_we   = 1'b0;
        case (state)
            TX_IDLE: begin
                if (gnt_any) begin
                    req_ready = gnt & {NREQ{resetn}};
                    state_nxt = TX_WRITE;
                end
            end
            TX_WRITE: begin
                uart_we = 1'b1;
                if (!uart_wait) state_nxt = TX_GAP;
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    assign uart_di = uart_we ? {{(32-UART_BYTE_W){1'b0}}, tx_byte} : '0;

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            state   <= TX_IDLE;
            rr_ptr  <= '0;
            tx_byte <= '0;
        end else begin
            state <= state_nxt;
            if (state == TX_IDLE && gnt_any) begin
                tx_byte <= req_data[gnt_idx*UART_BYTE_W +: UART_BYTE_W];
                rr_ptr  <= (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    // Bit 8 clear marks a pending byte; uart_re high masks the stale byte still shown that cycle.
    assign byte_pending = ~uart_do[UART_BYTE_W];
    assign unused_do    = ^uart_do[31:UART_BYTE_W+1];

    always_ff @(posedge hw_clk or negedge resetn) begin
        if (!resetn) begin
            rx_valid <= 1'b0;
            uart_re  <= 1'b0;
            rx_data  <= '0;
        end else if (byte_pending && !uart_re) begin
            rx_valid <= 1'b1;
            uart_re  <= 1'b1;
            rx_data  <= uart_do[UART_BYTE_W-1:0];
        end else begin
            rx_valid <= 1'b0;
            uart_re  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_port_arbiter.sv
// Directed and randomized bench for uart_port_arbiter with a timing-rule reference model.
module tb_uart_port_arbiter;
    import uart_ctrl_pkg::*;

    localparam int NREQ = 2;

    logic                hw_clk = 1'b0;
    logic                resetn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*8-1:0]   req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic                uart_we;
    logic [31:0]         uart_di;
    logic                uart_wait;
    logic                uart_re;
    logic [31:0]         uart_do;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int acc_cnt = 0;
    int rx_cnt  = 0;

    always #5 hw_clk = ~hw_clk;

    uart_port_arbiter #(.NREQ(NREQ)) dut (
        .hw_clk    (hw_clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .uart_we   (uart_we),
        .uart_di   (uart_di),
        .uart_wait (uart_wait),
        .uart_re   (uart_re),
        .uart_do   (uart_do)
    );

    always @(posedge hw_clk) begin
        if (resetn && uart_we && !uart_wait) acc_cnt <= acc_cnt + 1;
        if (resetn && rx_valid) rx_cnt <= rx_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge hw_clk);
        #1;
    endtask

    task automatic samp();
        @(negedge hw_clk);
    endtask

    // reference model state for the random phase
    int              p, g, next_free, acc0, rxc0;
    bit              wr_active, rx_present, re_s, rx_new_prev, rx_new;
    logic [7:0]      wr_byte, rx_cur, exp_rxd;
    logic [NREQ-1:0] exp_ready;
    bit              exp_rxv;

    initial begin
        resetn    = 1'b0;
        req_valid = 2'b11;
        req_data  = {8'h32, 8'h31};
        uart_wait = 1'b0;
        uart_do   = UART_NO_DATA;

        // reset held with both requests asserted
        samp(); samp();
        check("rst_ready", req_ready, 2'b00);
        check("rst_we", uart_we, 1'b0);
        check("rst_re", uart_re, 1'b0);
        check("rst_di", uart_di, 32'h0);
        check("rst_rxv", rx_valid, 1'b0);
        check("rst_rxd", rx_data, 8'h00);
        resetn = 1'b1;
        #1;
        check("first_grant_r0", req_ready, 2'b01);
        tick(); req_valid = '0;
        samp();
        check("first_we", uart_we, 1'b1);
        check("first_di", uart_di, 32'h31);
        tick(); samp();
        check("first_gap", uart_we, 1'b0);
        tick();

        // single write, UART idle
        req_valid = 2'b01; req_data[7:0] = 8'h50;
        samp();
        check("single_ready", req_ready, 2'b01);
        check("single_we_c0", uart_we, 1'b0);
        tick(); req_valid = '0;
        samp();
        check("single_we_c1", uart_we, 1'b1);
        check("single_di_c1", uart_di, 32'h0000_0050);
        tick(); samp();
        check("single_we_c2", uart_we, 1'b0);
        tick();
        req_valid = 2'b01; req_data[7:0] = 8'h51;
        samp();
        check("single_idle_c3", req_ready, 2'b01);
        tick(); req_valid = '0;
        samp();
        check("single2_di", uart_di, 32'h51);
        tick(); samp(); tick();

        // busy UART: 4 wait cycles
        req_valid = 2'b10; req_data[15:8] = 8'h77;
        samp();
        check("busy_ready", req_ready, 2'b10);
        acc0 = acc_cnt;
        tick(); req_valid = '0; uart_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            samp();
            check("busy_we_hold", uart_we, 1'b1);
            check("busy_di_hold", uart_di, 32'h77);
            tick();
        end
        uart_wait = 1'b0;
        samp();
        check("busy_we_last", uart_we, 1'b1);
        check("busy_di_last", uart_di, 32'h77);
        tick(); samp();
        check("busy_gap", uart_we, 1'b0);
        check("busy_one_accept", acc_cnt - acc0, 1);
        tick();

        // fairness with both requesters continuously valid
        req_valid = 2'b11; req_data = {8'h32, 8'h31};
        for (int i = 0; i < 4; i++) begin
            samp();
            check("fair_ready", req_ready, (i % 2 == 1) ? 2'b10 : 2'b01);
            tick(); samp();
            check("fair_di", uart_di, (i % 2 == 1) ? 32'h32 : 32'h31);
            tick(); tick();
        end
        req_valid = '0;

        // receive one byte
        rxc0 = rx_cnt;
        uart_do = 32'h0000_0033;
        samp();
        check("rx_k_valid", rx_valid, 1'b0);
        check("rx_k_re", uart_re, 1'b0);
        tick(); samp();
        check("rx_k1_valid", rx_valid, 1'b1);
        check("rx_k1_re", uart_re, 1'b1);
        check("rx_k1_data", rx_data, 8'h33);
        tick(); uart_do = UART_NO_DATA;
        samp();
        check("rx_k2_valid", rx_valid, 1'b0);
        check("rx_k2_re", uart_re, 1'b0);
        check("rx_hold_data", rx_data, 8'h33);
        tick(); samp();
        check("rx_one_pulse", rx_cnt - rxc0, 1);

        // concurrent TX/RX, then reset in the middle of a write
        tick(); req_valid = 2'b01; req_data[7:0] = 8'hAA;
        samp();
        check("cc_ready", req_ready, 2'b01);
        tick(); req_valid = '0; uart_wait = 1'b1; uart_do = 32'h0000_0044;
        samp();
        check("cc_we", uart_we, 1'b1);
        check("cc_di", uart_di, 32'hAA);
        tick(); samp();
        check("cc_rx_valid", rx_valid, 1'b1);
        check("cc_rx_data", rx_data, 8'h44);
        check("cc_we_during_rx", uart_we, 1'b1);
        tick(); uart_do = UART_NO_DATA;
        samp();
        check("cc_we_before_rst", uart_we, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("midrst_we", uart_we, 1'b0);
        check("midrst_di", uart_di, 32'h0);
        check("midrst_re", uart_re, 1'b0);
        check("midrst_rxd", rx_data, 8'h00);
        tick();
        resetn = 1'b1; uart_wait = 1'b0;
        req_valid = 2'b10; req_data[15:8] = 8'hBB;
        samp();
        check("midrst_idle_grant", req_ready, 2'b10);
        tick(); req_valid = '0;
        samp();
        check("midrst_new_di", uart_di, 32'hBB);
        tick(); samp();

        // randomized phase
        p = 0; next_free = 0; wr_active = 0; wr_byte = '0;
        rx_present = 0; re_s = 0; rx_new_prev = 0; exp_rxd = 8'h00; rx_cur = '0;
        acc0 = acc_cnt;
        for (int t = 0; t < 600; t++) begin
            tick();
            req_valid = NREQ'($urandom);
            req_data  = 16'($urandom);
            uart_wait = ($urandom_range(0, 3) == 0);
            if (re_s) rx_present = 0;
            rx_new = 0;
            if (!rx_present && t < 590 && $urandom_range(0, 2) == 0) begin
                rx_cur = 8'($urandom);
                rx_present = 1;
                rx_new = 1;
            end
            uart_do = rx_present ? {24'h0, rx_cur} : UART_NO_DATA;
            exp_rxv = rx_new_prev;
            if (rx_new_prev) exp_rxd = rx_cur;
            exp_ready = '0;
            g = 0;
            if (!wr_active && t >= next_free) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (exp_ready == '0 && req_valid[(p + k) % NREQ]) begin
                        g = (p + k) % NREQ;
                        exp_ready[g] = 1'b1;
                    end
                end
            end
            samp();
            check("rnd_ready", req_ready, exp_ready);
            check("rnd_we", uart_we, wr_active);
            if (wr_active) check("rnd_di", uart_di, {24'h0, wr_byte});
            check("rnd_rxv", rx_valid, exp_rxv);
            check("rnd_re", uart_re, exp_rxv);
            check("rnd_rxd", rx_data, exp_rxd);
            re_s = uart_re;
            if (wr_active && !uart_wait) begin
                wr_active = 0;
                next_free = t + 2;
            end
            if (exp_ready != '0) begin
                wr_active = 1;
                wr_byte = req_data[g*8 +: 8];
                p = (g + 1) % NREQ;
            end
            rx_new_prev = rx_new;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
